lfp_mul_serial: RTL and testbench

Parametrised byte-serial logarithmic (Mitchell) approximate floating-point multiplier for the Tiny Tapeout pin budget. It generalises the fixed 16-bit half-precision block to any IEEE-like format with EXP_W/MAN_W, adds valid/ready handshakes on both sides, backpressured byte-serial result readout, and exception flags. It sits behind the top-level pin wrapper: operand A arrives on the dedicated inputs and operand B on the bidirectional inputs; the result leaves on the dedicated outputs.

---
 rtl/lfp_pkg.sv | 33 +++
 rtl/lfp_mitchell_core.sv | 65 ++++++
 rtl/lfp_mul_serial.sv | 111 +++++++++++
 tb/tb_lfp_mul_serial.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfp_pkg.sv
// Shared types and format helpers for the byte-serial Mitchell multiplier.
package lfp_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam int unsigned FlagZero = 0;
    localparam int unsigned FlagUnf  = 1;
    localparam int unsigned FlagOvf  = 2;
    localparam int unsigned FlagInf  = 3;
    localparam int unsigned FlagNan  = 4;

    function automatic int unsigned calc_w(input int unsigned exp_w, input int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int unsigned calc_nb(input int unsigned exp_w, input int unsigned man_w);
        return (calc_w(exp_w, man_w) + 7) / 8;
    endfunction

    function automatic int unsigned calc_bias(input int unsigned exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Positive quiet NaN: all-ones exponent with only the mantissa MSB set.
    function automatic logic [31:0] canon_nan(input int unsigned exp_w, input int unsigned man_w);
        return (((32'd1 << exp_w) - 32'd1) << man_w) | (32'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/lfp_mitchell_core.sv
// Combinational Mitchell multiply: classify operands, add biased magnitudes, saturate.
module lfp_mitchell_core
    import lfp_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_res,
    output logic [4:0]   o_flags
);

    localparam logic [EXP_W-1:0]  ExpOnes = '1;
    localparam logic signed [W:0] BiasSh  = (W + 1)'(calc_bias(EXP_W)) << MAN_W;
    localparam logic signed [W:0] MinNorm = (W + 1)'(1) << MAN_W;
    localparam logic signed [W:0] OvfLim  = (W + 1)'((1 << EXP_W) - 1) << MAN_W;

    logic             w_sign;
    logic             w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    logic             w_nan, w_inf, w_zero;
    logic signed [W:0] w_sum;

    assign w_sign   = i_a[W-1] ^ i_b[W-1];
    assign w_nan_a  = (i_a[W-2:MAN_W] == ExpOnes) && (i_a[MAN_W-1:0] != '0);
    assign w_nan_b  = (i_b[W-2:MAN_W] == ExpOnes) && (i_b[MAN_W-1:0] != '0);
    assign w_inf_a  = (i_a[W-2:MAN_W] == ExpOnes) && (i_a[MAN_W-1:0] == '0);
    assign w_inf_b  = (i_b[W-2:MAN_W] == ExpOnes) && (i_b[MAN_W-1:0] == '0);
    // Subnormals are flushed, so any zero exponent counts as zero.
    assign w_zero_a = (i_a[W-2:MAN_W] == '0);
    assign w_zero_b = (i_b[W-2:MAN_W] == '0);

    assign w_nan  = w_nan_a || w_nan_b || (w_inf_a && w_zero_b) || (w_inf_b && w_zero_a);
    assign w_inf  = w_inf_a || w_inf_b;
    assign w_zero = w_zero_a || w_zero_b;

    assign w_sum = $signed({2'b00, i_a[W-2:0]}) + $signed({2'b00, i_b[W-2:0]}) - BiasSh;

    always_comb begin
        o_res   = '0;
        o_flags = '0;
        if (w_nan) begin
            o_res             = W'(canon_nan(EXP_W, MAN_W));
            o_flags[FlagNan]  = 1'b1;
        end else if (w_inf) begin
            o_res             = {w_sign, ExpOnes, {MAN_W{1'b0}}};
            o_flags[FlagInf]  = 1'b1;
        end else if (w_zero) begin
            o_res             = {w_sign, {(W-1){1'b0}}};
            o_flags[FlagZero] = 1'b1;
        end else if (w_sum < MinNorm) begin
            o_res             = {w_sign, {(W-1){1'b0}}};
            o_flags[FlagUnf]  = 1'b1;
            o_flags[FlagZero] = 1'b1;
        end else if (w_sum >= OvfLim) begin
            o_res             = {w_sign, ExpOnes, {MAN_W{1'b0}}};
            o_flags[FlagOvf]  = 1'b1;
            o_flags[FlagInf]  = 1'b1;
        end else begin
            o_res = {w_sign, w_sum[W-2:0]};
        end
    end

endmodule

// File: rtl/lfp_mul_serial.sv
// Byte-serial approximate FP multiplier: load operands LSB byte first, compute, stream result.
module lfp_mul_serial
    import lfp_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last,
    output logic [4:0] flags
);

    localparam int unsigned W       = calc_w(EXP_W, MAN_W);
    localparam int unsigned NB      = calc_nb(EXP_W, MAN_W);
    localparam logic [1:0]  LastCnt = 2'(NB - 1);

    state_e         r_state;
    logic [1:0]     r_cnt;
    logic [W-1:0]   r_a, r_b, r_res;
    logic [4:0]     r_flags;
    logic [W-1:0]   w_res;
    logic [4:0]     w_flags;
    logic [7:0]     w_byte;

    lfp_mitchell_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_core (
        .i_a     (r_a),
        .i_b     (r_b),
        .o_res   (w_res),
        .o_flags (w_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        // Only bits below W are stored; padding in the top beat is dropped.
                        for (int j = 0; j < W; j++) begin
                            if (r_cnt == 2'(j / 8)) begin
                                r_a[j] <= a_byte[j % 8];
                                r_b[j] <= b_byte[j % 8];
                            end
                        end
                        if (r_cnt == LastCnt) begin
                            r_cnt   <= '0;
                            r_state <= CALC;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                CALC: begin
                    r_res   <= w_res;
                    r_flags <= w_flags;
                    r_cnt   <= '0;
                    r_state <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        if (r_cnt == LastCnt) begin
                            r_cnt   <= '0;
                            r_state <= LOAD;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= LOAD;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = '0;
        if (r_state == SEND) begin
            for (int j = 0; j < W; j++) begin
                if (r_cnt == 2'(j / 8)) begin
                    w_byte[j % 8] = r_res[j];
                end
            end
        end
    end

    assign in_ready  = (r_state == LOAD);
    assign out_valid = (r_state == SEND);
    assign out_last  = (r_state == SEND) && (r_cnt == LastCnt);
    assign out_byte  = w_byte;
    assign flags     = r_flags;

endmodule

// File: tb/tb_lfp_mul_serial.sv
// Scoreboard bench: half-precision instance plus an 8-bit (single-beat) instance.
module tb_lfp_mul_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0] a_byte, b_byte, out_byte;
    logic [4:0] flags;

    logic       in_valid_s, in_ready_s, out_valid_s, out_ready_s, out_last_s;
    logic [7:0] a_byte_s, b_byte_s, out_byte_s;
    logic [4:0] flags_s;

    lfp_mul_serial #(.EXP_W(5), .MAN_W(10)) u_dut16 (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
        .a_byte (a_byte), .b_byte (b_byte), .out_valid (out_valid), .out_ready (out_ready),
        .out_byte (out_byte), .out_last (out_last), .flags (flags)
    );

    lfp_mul_serial #(.EXP_W(4), .MAN_W(3)) u_dut8 (
        .clk (clk), .rst (rst), .in_valid (in_valid_s), .in_ready (in_ready_s),
        .a_byte (a_byte_s), .b_byte (b_byte_s), .out_valid (out_valid_s),
        .out_ready (out_ready_s), .out_byte (out_byte_s), .out_last (out_last_s),
        .flags (flags_s)
    );

    int          n_cmp, n_bad;
    logic [36:0] q16[$];
    logic [36:0] q8[$];
    int          rdy_mode;
    time         t_first16, t_first8;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endfunction

    // Mitchell product in the log domain: exponents add, fractions add with carry into exponent.
    function automatic logic [36:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input int e, input int m);
        int w, bias, emax, ea, eb, fa, fb, ex, fr;
        logic [31:0] sbit, inf_w, nan_w;
        bit na, nb, ia, ib, za, zb;
        w     = 1 + e + m;
        bias  = (1 << (e - 1)) - 1;
        emax  = (1 << e) - 1;
        ea    = int'((a >> m) & 32'(emax));
        eb    = int'((b >> m) & 32'(emax));
        fa    = int'(a & 32'((1 << m) - 1));
        fb    = int'(b & 32'((1 << m) - 1));
        sbit  = ((a ^ b) >> (w - 1)) & 32'd1;
        sbit  = sbit << (w - 1);
        inf_w = sbit | 32'(emax << m);
        nan_w = 32'(emax << m) | 32'(1 << (m - 1));
        na = (ea == emax) && (fa != 0);
        nb = (eb == emax) && (fb != 0);
        ia = (ea == emax) && (fa == 0);
        ib = (eb == emax) && (fb == 0);
        za = (ea == 0);
        zb = (eb == 0);
        if (na || nb || (ia && zb) || (ib && za)) return {5'b10000, nan_w};
        if (ia || ib) return {5'b01000, inf_w};
        if (za || zb) return {5'b00001, sbit};
        ex = ea + eb - bias;
        fr = fa + fb;
        if (fr >= (1 << m)) begin
            ex++;
            fr -= (1 << m);
        end
        if (ex < 1) return {5'b00011, sbit};
        if (ex >= emax) return {5'b01100, inf_w};
        return {5'b00000, sbit | 32'(ex << m) | 32'(fr)};
    endfunction

    function automatic logic [31:0] rand_op(input int e, input int m);
        logic [31:0] v, emask;
        int emax;
        emax  = (1 << e) - 1;
        emask = 32'(emax << m);
        v     = $urandom & 32'((64'd1 << (1 + e + m)) - 1);
        case ($urandom_range(0, 7))
            0: v = v & ~emask;
            1: v = v | emask;
            2: v = (v | emask) & ~32'((1 << m) - 1);
            default: v = (v & ~emask) | 32'($urandom_range(1, emax - 1) << m);
        endcase
        return v;
    endfunction

    task automatic send16(input logic [15:0] a, input logic [15:0] b,
                          input logic [36:0] exp, input bit gaps);
        int tries;
        q16.push_back(exp);
        for (int k = 0; k < 2; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
            @(negedge clk);
            in_valid = 1'b1;
            a_byte   = a[k*8 +: 8];
            b_byte   = b[k*8 +: 8];
            tries    = 0;
            while (!in_ready && tries < 100) begin
                @(negedge clk);
                tries++;
            end
            if (tries >= 100) fail_now("in_ready16_wait");
            if (k == 0) t_first16 = $time;
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [36:0] exp);
        int tries;
        q8.push_back(exp);
        @(negedge clk);
        in_valid_s = 1'b1;
        a_byte_s   = a;
        b_byte_s   = b;
        tries      = 0;
        while (!in_ready_s && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 100) fail_now("in_ready8_wait");
        t_first8 = $time;
        @(posedge clk);
        #1 in_valid_s = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q16.size() != 0 || q8.size() != 0 || out_valid || out_valid_s) && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (t >= 500) fail_now("drain");
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end

    int          beat16;
    logic [15:0] word16;
    logic [4:0]  fl16, hf16;
    logic [7:0]  hb16;
    logic        hl16;
    bit          held16;
    logic [36:0] e16, e8;

    always @(negedge clk) begin
        if (rst) begin
            beat16 = 0;
            held16 = 0;
            word16 = '0;
        end else if (out_valid) begin
            chk("in_ready_in_send16", in_ready, 0);
            if (held16) begin
                chk("hold_byte16", out_byte, hb16);
                chk("hold_flags16", flags, hf16);
                chk("hold_last16", out_last, hl16);
            end
            if (beat16 > 0) chk("flags_stable16", flags, fl16);
            fl16 = flags;
            if (out_ready) begin
                held16 = 0;
                word16[beat16*8 +: 8] = out_byte;
                chk("last16", out_last, beat16 == 1);
                if (beat16 == 1) begin
                    if (q16.size() == 0) begin
                        fail_now("unexpected_result16");
                    end else begin
                        e16 = q16.pop_front();
                        chk("res16", word16, e16[15:0]);
                        chk("flags16", flags, e16[36:32]);
                    end
                    beat16 = 0;
                end else begin
                    beat16++;
                end
            end else begin
                held16 = 1;
                hb16   = out_byte;
                hf16   = flags;
                hl16   = out_last;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_s && out_ready_s) begin
            chk("in_ready_in_send8", in_ready_s, 0);
            chk("last8", out_last_s, 1);
            if (q8.size() == 0) begin
                fail_now("unexpected_result8");
            end else begin
                e8 = q8.pop_front();
                chk("res8", out_byte_s, e8[7:0]);
                chk("flags8", flags_s, e8[36:32]);
            end
        end
    end

    logic [15:0] da[6] = '{16'h3E00, 16'hC000, 16'h7800, 16'h0400, 16'h7C00, 16'hFC00};
    logic [15:0] db[6] = '{16'h4200, 16'h3C00, 16'h7800, 16'h0400, 16'h0000, 16'h4000};
    logic [15:0] dr[6] = '{16'h4400, 16'hC000, 16'h7C00, 16'h0000, 16'h7E00, 16'hFC00};
    logic [4:0]  df[6] = '{5'b00000, 5'b00000, 5'b01100, 5'b00011, 5'b10000, 5'b01000};

    initial begin
        time         prev;
        int          tries;
        logic [31:0] ra, rb;
        n_cmp = 0; n_bad = 0; rdy_mode = 0;
        rst = 1'b1;
        in_valid = 1'b0; a_byte = '0; b_byte = '0; out_ready = 1'b1;
        in_valid_s = 1'b0; a_byte_s = '0; b_byte_s = '0; out_ready_s = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready16", in_ready, 1);
        chk("rst_out_valid16", out_valid, 0);
        chk("rst_out_last16", out_last, 0);
        chk("rst_out_byte16", out_byte, 0);
        chk("rst_flags16", flags, 0);
        chk("rst_in_ready8", in_ready_s, 1);
        chk("rst_out_valid8", out_valid_s, 0);
        rst = 1'b0;

        send16(16'h0000, 16'h0000, {5'b00001, 32'h0}, 0);
        @(negedge clk);
        chk("latency_edge1", out_valid, 0);
        @(negedge clk);
        chk("latency_edge2", out_valid, 1);
        drain();

        prev = 0;
        for (int i = 0; i < 6; i++) begin
            send16(da[i], db[i], {df[i], 16'h0, dr[i]}, 0);
            if (i > 0) chk("throughput16", t_first16 - prev, 50);
            prev = t_first16;
        end
        drain();

        // One stray beat, then reset: the next operation must start from beat 0.
        @(negedge clk);
        in_valid = 1'b1; a_byte = 8'h11; b_byte = 8'h22;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_flags", flags, 0);
        chk("midrst_out_valid", out_valid, 0);
        send16(16'h3E00, 16'h4200, {5'b00000, 32'h4400}, 0);
        drain();

        rdy_mode = 2;
        out_ready = 1'b0;
        send16(16'h3E00, 16'h4200, {5'b00000, 32'h4400}, 0);
        tries = 0;
        do begin
            @(posedge clk);
            #2 tries++;
        end while (!out_valid && tries < 50);
        if (tries >= 50) fail_now("bp_out_valid_wait");
        out_ready = 1'b1;
        @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_byte", out_byte, 8'h44);
            chk("bp_last", out_last, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_flags", flags, 0);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        rdy_mode = 0;
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            ra = rand_op(5, 10);
            rb = rand_op(5, 10);
            send16(ra[15:0], rb[15:0], ref_mul(ra, rb, 5, 10), 1);
        end
        drain();
        rdy_mode = 0;

        send8(8'h38, 8'h40, {5'b00000, 32'h40});
        prev = t_first8;
        for (int i = 0; i < 60; i++) begin
            ra = rand_op(4, 3);
            rb = rand_op(4, 3);
            send8(ra[7:0], rb[7:0], ref_mul(ra, rb, 4, 3));
            chk("throughput8", t_first8 - prev, 30);
            prev = t_first8;
        end
        drain();

        chk("q16_empty", q16.size(), 0);
        chk("q8_empty", q8.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
